axis_frame_packer: RTL and testbench
====================================

AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 Parameter FRAME_LEN, default 16; data beats per frame; legal range 2..31.
REQ-002 Parameter FIFO_DEPTH, default 4; input buffer entries; power of two, 2..16.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port s_data  input  8  raw byte from source.
REQ-006 Port s_valid  input  1  s_data valid.
REQ-007 Port s_ready  output  1  block can accept a byte.
REQ-008 Port m_data  output  8  AXI-Stream byte to downstream 8-bit register stage.
REQ-009 Port m_valid  output  1  m_data valid (drives downstream T_valid_in).
REQ-010 Port m_ready  input  1  downstream ready (T_ready).
REQ-011 Port m_last  output  1  final beat of frame (drives downstream Tlast).
REQ-012 Port frame_cnt  output  5  completed frames emitted, wraps 31->0.

Function
REQ-013 Input accept SHALL occur when s_valid && s_ready; s_ready SHALL equal !fifo_full, registered-state based, with no combinational path from m_ready.
REQ-014 FIFO SHALL be first-word fall-through: a byte accepted at edge N SHALL appear on m_data with m_valid=1 after edge N if the FIFO was empty, giving 1-cycle latency.
REQ-015 Output beat SHALL occur when m_valid && m_ready; the FIFO pops only on a data beat.
REQ-016 While m_valid=1 and m_ready=0, m_data, m_valid and m_last SHALL hold stable.
REQ-017 A simultaneous push and pop SHALL leave the occupancy unchanged and be legal at any non-full occupancy; no push when full; no pop when empty.
REQ-018 The FSM SHALL have two states, DATA and CSUM; reset state is DATA.
REQ-019 A 5-bit beat_idx SHALL count data beats in the current frame, 0..FRAME_LEN-1.
REQ-020 In DATA, m_valid SHALL equal !fifo_empty; on a data beat with beat_idx=FRAME_LEN-1, beat_idx SHALL return to 0.
REQ-021 m_last SHALL assert only on the final beat of a frame; frame_cnt SHALL increment on the edge of that beat's handshake.
REQ-022 Pointer and occupancy arithmetic SHALL wrap modulo FIFO_DEPTH; frame_cnt SHALL wrap modulo 32.

Reset
REQ-023 Reset SHALL force: FIFO empty, s_ready=1, m_valid=0, m_last=0, m_data=8'h00, beat_idx=0, frame_cnt=0, state=DATA, checksum=8'h00.
REQ-024 Reset mid-frame SHALL discard buffered bytes and the partial frame; the first beat after release is beat 0 of a new frame.

Configuration
REQ-025 Macro AXIS_PACKER_CHECKSUM_EN undefined: frames SHALL be FRAME_LEN data beats, with m_last on beat FRAME_LEN-1 and no CSUM state reachable.
REQ-026 Macro AXIS_PACKER_CHECKSUM_EN defined, data beats: data beats SHALL carry m_last=0, and a running XOR of the frame's data bytes SHALL be kept.
REQ-027 Macro AXIS_PACKER_CHECKSUM_EN defined, CSUM entry: after data beat FRAME_LEN-1 the FSM SHALL enter CSUM.
REQ-028 Macro AXIS_PACKER_CHECKSUM_EN defined, CSUM beat: CSUM SHALL drive m_valid=1, m_data=XOR result and m_last=1, and SHALL not pop the FIFO.
REQ-029 Macro AXIS_PACKER_CHECKSUM_EN defined, CSUM exit: on the CSUM handshake the XOR SHALL clear, frame_cnt SHALL increment and the FSM SHALL return to DATA.
REQ-030 Macro AXIS_PACKER_CHECKSUM_EN defined, buffering: input acceptance SHALL continue during CSUM while the FIFO is not full.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (DATA, CSUM), the byte width constant 8 and the frame counter width constant 5.
REQ-032 The FIFO SHALL be a sub-module axis_byte_fifo, with push/pop/full/empty ports and FIFO_DEPTH as parameter.

Verification
REQ-033 Scenario 1, FRAME_LEN=4, macro off, m_ready=1: push 8'h01..8'h08 back-to-back -> output 01..08, m_last on 04 and 08, frame_cnt=2.
REQ-034 Scenario 2, FIFO_DEPTH=4, m_ready=0: push 6 bytes -> s_ready=0 after the 4th accept, and only 4 bytes are stored; m_data=first byte held stable.
REQ-035 Scenario 3, macro on, FRAME_LEN=4: data 8'h11,8'h22,8'h44,8'h88 -> a 5th beat 8'hFF with m_last=1, and frame_cnt=1.
REQ-036 Scenario 4, m_ready toggling 1,0,1,0: every byte emitted exactly once and in order, with no change while stalled.
REQ-037 Scenario 5: assert reset after 2 beats of a frame -> all outputs at reset values; the next frame's m_last falls FRAME_LEN beats after release.
REQ-038 Scenario 6: emit 33 frames -> frame_cnt reads 1 (wrap).

Source files
------------

// File: rtl/axis_frame_packer_pkg.sv
// rtl/axis_frame_packer_pkg.sv - shared types and widths for the frame packer
// Purpose: FSM state type, byte width and frame counter width used by the
//          packer, its interface and its input FIFO.
// Ports:   none (package).
package axis_frame_packer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic {
    DATA = 1'b0,
    CSUM = 1'b1
  } pack_state_e;

endpackage

// File: rtl/axis_frame_packer_if.sv
// rtl/axis_frame_packer_if.sv - byte-in / framed-byte-out bus of the packer
// Purpose: bundles the source handshake, the downstream stream and the frame
//          counter of axis_frame_packer.
// Ports:   none; modport master = packer side, modport slave = environment side.
//          s_data/s_valid/s_ready  source byte handshake
//          m_data/m_valid/m_ready/m_last  downstream stream
//          frame_cnt  completed frames, wraps modulo 32
interface axis_frame_packer_if;
  import axis_frame_packer_pkg::*;

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last, frame_cnt
  );

  modport slave (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last, frame_cnt
  );

endinterface

// File: rtl/axis_byte_fifo.sv
// rtl/axis_byte_fifo.sv - first-word fall-through byte FIFO
// Purpose: buffers source bytes; the head entry is visible on dout_o while
//          empty_o is low, so a byte written at edge N is readable after N.
// Ports:   clk, reset (async, active-high)
//          push_i/din_i  write request and byte (ignored when full)
//          pop_i         read request (ignored when empty)
//          dout_o        head entry, full_o/empty_o occupancy flags
module axis_byte_fifo
  import axis_frame_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axis_frame_packer.sv
// rtl/axis_frame_packer.sv - packs a raw byte stream into fixed-length frames
// Purpose: buffers bytes in axis_byte_fifo and emits them as frames of
//          FRAME_LEN beats with m_last on the final beat. With
//          AXIS_PACKER_CHECKSUM_EN defined, each frame is followed by one
//          extra beat carrying the XOR of its data bytes, flagged m_last.
// Ports:   clk, reset (async, active-high)
//          bus (axis_frame_packer_if.master): s_* source handshake,
//          m_* downstream stream, frame_cnt completed frames (mod 32)
module axis_frame_packer
  import axis_frame_packer_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  axis_frame_packer_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  pack_state_e       state_q, state_d;
  logic [CNT_W-1:0]  beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [BYTE_W-1:0] fifo_dout;
  logic              last_beat;
  logic              m_valid_c, m_last_c;
  logic [BYTE_W-1:0] m_data_c;

  // s_ready depends only on FIFO state, never on m_ready.
  assign bus.s_ready   = !fifo_full;
  assign bus.m_valid   = m_valid_c;
  assign bus.m_data    = m_data_c;
  assign bus.m_last    = m_last_c;
  assign bus.frame_cnt = frame_cnt_q;
  assign last_beat     = (beat_idx_q == LAST_IDX);

  axis_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (bus.s_valid),
    .din_i  (bus.s_data),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    frame_cnt_d = frame_cnt_q;
    csum_d      = csum_q;
    fifo_pop    = 1'b0;
    m_valid_c   = 1'b0;
    m_data_c    = '0;
    m_last_c    = 1'b0;
    case (state_q)
      DATA: begin
        m_valid_c = !fifo_empty;
        // Stale FIFO storage is masked so an idle bus reads zero.
        m_data_c  = fifo_empty ? '0 : fifo_dout;
`ifndef AXIS_PACKER_CHECKSUM_EN
        m_last_c  = !fifo_empty && last_beat;
`endif
        if (!fifo_empty && bus.m_ready) begin
          fifo_pop   = 1'b1;
          beat_idx_d = last_beat ? '0 : beat_idx_q + 1'b1;
`ifdef AXIS_PACKER_CHECKSUM_EN
          csum_d = csum_q ^ fifo_dout;
          if (last_beat) state_d = CSUM;
`else
          if (last_beat) frame_cnt_d = frame_cnt_q + 1'b1;
`endif
        end
      end
      CSUM: begin
        // Trailer beat comes from the running XOR, not the FIFO.
        m_valid_c = 1'b1;
        m_data_c  = csum_q;
        m_last_c  = 1'b1;
        if (bus.m_ready) begin
          csum_d      = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = DATA;
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= DATA;
      beat_idx_q  <= '0;
      frame_cnt_q <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      frame_cnt_q <= frame_cnt_d;
      csum_q      <= csum_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_packer.sv
// tb/tb_axis_frame_packer.sv - self-checking bench for axis_frame_packer
module tb_axis_frame_packer;
  import axis_frame_packer_pkg::*;

  localparam int unsigned FL = 4;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  axis_frame_packer_if bus();

  axis_frame_packer #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [4:0] ec;
  } vec_t;

  vec_t tbl[$];

  logic [8:0] exp_q[$];
  int         m_beat = 0;
  logic [7:0] m_xor = 8'h00;
  logic [4:0] exp_frames = 5'd0;
  logic       stall_prev = 1'b0;
  logic [8:0] held_prev = 9'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] b);
`ifdef AXIS_PACKER_CHECKSUM_EN
    exp_q.push_back({1'b0, b});
    m_xor = m_xor ^ b;
    m_beat++;
    if (m_beat == FL) begin
      exp_q.push_back({1'b1, m_xor});
      m_xor = 8'h00;
      m_beat = 0;
    end
`else
    exp_q.push_back({(m_beat == FL - 1), b});
    m_beat = (m_beat == FL - 1) ? 0 : m_beat + 1;
`endif
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    m_beat = 0;
    m_xor = 8'h00;
    exp_frames = 5'd0;
    stall_prev = 1'b0;
  endfunction

  // Scoreboard: order, content, stall stability and frame count.
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev)
        check("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, held_prev});
      check("frame_cnt", bus.frame_cnt, exp_frames);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none", {bus.m_last, bus.m_data});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("beat", {bus.m_last, bus.m_data}, e);
          if (e[8]) exp_frames = exp_frames + 5'd1;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held_prev = {bus.m_last, bus.m_data};
      if (bus.s_valid && bus.s_ready) model_push(bus.s_data);
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 1);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_last"}, bus.m_last, 0);
    check({tag, "_m_data"}, bus.m_data, 8'h00);
    check({tag, "_frame_cnt"}, bus.frame_cnt, 0);
  endtask

  initial begin
    int acc;
    int idx;
    int pushed;
    int nb;
    logic found;

    bus.s_data = 8'h00;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    reset = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

`ifdef AXIS_PACKER_CHECKSUM_EN
    tbl.push_back('{1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h22, 1'b1, 8'h22, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h44, 1'b1, 8'h44, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h88, 1'b1, 8'h88, 1'b0, 5'd0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 5'd0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd1});
`else
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 8'(i + 1), 1'b1, 8'(i + 1), (i == 3 || i == 7), (i >= 4) ? 5'd1 : 5'd0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd2});
`endif

    // Table: back-to-back pushes with m_ready held high.
    bus.m_ready = 1'b1;
    foreach (tbl[i]) begin
      bus.s_valid = tbl[i].vin;
      bus.s_data = tbl[i].din;
      step();
      check("tbl_m_valid", bus.m_valid, tbl[i].ev);
      check("tbl_m_data", bus.m_data, tbl[i].ed);
      check("tbl_m_last", bus.m_last, tbl[i].el);
      check("tbl_frame_cnt", bus.frame_cnt, tbl[i].ec);
    end
    bus.s_valid = 1'b0;
    drain();

    // Full FIFO with a stalled sink.
    bus.m_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(8'hA0 + k);
      if (bus.s_ready) acc++;
      step();
    end
    bus.s_valid = 1'b0;
    check("full_accepted", acc, 4);
    check("full_s_ready", bus.s_ready, 0);
    check("full_head", bus.m_data, 8'hA0);
    check("full_valid", bus.m_valid, 1);
    step();
    step();
    check("full_head_held", bus.m_data, 8'hA0);
    bus.m_ready = 1'b1;
    drain();

    // Toggling m_ready.
    idx = 0;
    for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
      bus.m_ready = (cyc % 2 == 0);
      bus.s_valid = 1'b1;
      bus.s_data = 8'(8'h30 + idx);
      if (bus.s_ready) idx++;
      step();
    end
    bus.s_valid = 1'b0;
    check("toggle_all_sent", idx, 8);
    for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
      bus.m_ready = (cyc % 2 == 0);
      step();
    end
    bus.m_ready = 1'b1;
    drain();

    // Reset in the middle of a frame with bytes still buffered.
    bus.m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(8'h50 + k);
      step();
    end
    bus.m_ready = 1'b0;
    bus.s_data = 8'h52;
    step();
    bus.s_data = 8'h53;
    step();
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    step();
    reset = 1'b0;
    bus.m_ready = 1'b1;
    pushed = 0;
    nb = 0;
    found = 1'b0;
    for (int cyc = 0; cyc < 60 && !found; cyc++) begin
      bus.s_valid = (pushed < FL);
      bus.s_data = 8'(8'h60 + pushed);
      if (bus.s_valid && bus.s_ready) pushed++;
      if (bus.m_valid && bus.m_ready) begin
        nb++;
        if (bus.m_last) found = 1'b1;
      end
      step();
    end
    bus.s_valid = 1'b0;
    check("midreset_last_seen", found, 1);
`ifdef AXIS_PACKER_CHECKSUM_EN
    check("midreset_last_pos", nb, FL + 1);
`else
    check("midreset_last_pos", nb, FL);
`endif
    drain();

    // 33 frames wrap the 5-bit frame counter to 1.
    reset = 1'b1;
    clear_model();
    step();
    reset = 1'b0;
    bus.m_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 2000 && idx < 33 * FL; cyc++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(idx);
      if (bus.s_ready) idx++;
      step();
    end
    bus.s_valid = 1'b0;
    check("wrap_all_sent", idx, 33 * FL);
    drain();
    check("wrap_frame_cnt", bus.frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
